// File: rtl/adc_test_pkg.sv
// Shared types and constants for the ADC capture controller.
// Holds the capture FSM encoding and the per-FIFO decimation factors.
package adc_test_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'b001,
    CAPTURE = 3'b010,
    DONE    = 3'b100
  } cap_state_t;

  // log2 of the boxcar length for FIFO2, FIFO4 and FIFO8
  localparam int DEC_LOG2 [3] = '{1, 2, 3};

endpackage

// File: rtl/adc_capture_ctrl_if.sv
// ADC sample input plus the write/status side of the four sample FIFOs.
// The capture controller is the master; the FIFOs and the ADC form the slave side.
interface adc_capture_ctrl_if #(
  parameter int unsigned DATA_W = 14
);

  logic [DATA_W-1:0] adc_data;
  logic              adc_valid;
  logic              empty1, empty2, empty4, empty8;
  logic              ffull1, ffull2, ffull4, ffull8;
  logic              wr_en1, wr_en2, wr_en4, wr_en8;
  logic [DATA_W-1:0] din1, din2, din4, din8;

  modport master (
    input  adc_data, adc_valid,
    input  empty1, empty2, empty4, empty8,
    input  ffull1, ffull2, ffull4, ffull8,
    output wr_en1, wr_en2, wr_en4, wr_en8,
    output din1, din2, din4, din8
  );

  modport slave (
    output adc_data, adc_valid,
    output empty1, empty2, empty4, empty8,
    output ffull1, ffull2, ffull4, ffull8,
    input  wr_en1, wr_en2, wr_en4, wr_en8,
    input  din1, din2, din4, din8
  );

endinterface

// File: rtl/boxcar_decim.sv
// Boxcar decimator: sums 2**LOG2K accepted samples and emits their floored mean.
// The output strobe and data are registered and pulse once per completed group.
module boxcar_decim #(
  parameter int unsigned DATA_W = 14,
  parameter int unsigned LOG2K  = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  localparam int unsigned ACC_W = DATA_W + LOG2K;

  logic [LOG2K-1:0] r_phase;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_sum;

  // Accumulator is wide enough for 2**LOG2K full-scale samples
  assign w_sum = r_acc + ACC_W'(in_data);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_phase   <= '0;
      r_acc     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= 1'b0;
      if (clr) begin
        r_phase <= '0;
        r_acc   <= '0;
      end else if (in_valid) begin
        r_phase <= r_phase + LOG2K'(1);
        if (&r_phase) begin
          out_valid <= 1'b1;
          out_data  <= DATA_W'(w_sum >> LOG2K);
          r_acc     <= '0;
        end else begin
          r_acc <= w_sum;
        end
      end
    end
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Captures one block of ADC samples on arm and feeds FIFO1 at full rate and
// FIFO2/4/8 with 2/4/8-sample boxcar means; flags full until the FIFOs drain.
module adc_capture_ctrl
  import adc_test_pkg::*;
#(
  parameter int unsigned DATA_W  = 14,
  parameter int unsigned SAMPLES = 1024
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               arm,
  adc_capture_ctrl_if.master bus,
  output logic               full,
  output logic               busy,
  output logic               overflow
);

  localparam int unsigned CNT_W = $clog2(8 * SAMPLES) + 1;
  localparam logic [CNT_W-1:0] LAST_N = CNT_W'(8 * SAMPLES - 1);

  cap_state_t        r_state;
  logic [CNT_W-1:0]  r_n;
  logic              r_seen;
  logic              r_wr_en1;
  logic [DATA_W-1:0] r_din1;

  logic              w_accept;
  logic              w_clr;
  logic              w_all_empty;
  logic              w_ovf;
  logic [2:0]        w_dec_in_valid;
  logic [2:0]        w_dec_valid;
  logic [DATA_W-1:0] w_dec_data [3];

  assign w_accept    = (r_state == CAPTURE) && bus.adc_valid;
  assign w_clr       = (r_state == IDLE) && arm;
  assign w_all_empty = bus.empty1 && bus.empty2 && bus.empty4 && bus.empty8;

  // Each decimator only sees the first K*SAMPLES accepted samples
  for (genvar g = 0; g < 3; g++) begin : g_dec
    localparam int unsigned LOG2K = DEC_LOG2[g];

    assign w_dec_in_valid[g] = w_accept && (r_n < CNT_W'(SAMPLES << LOG2K));

    boxcar_decim #(
      .DATA_W (DATA_W),
      .LOG2K  (LOG2K)
    ) u_dec (
      .clk       (clk),
      .rstn      (rstn),
      .clr       (w_clr),
      .in_valid  (w_dec_in_valid[g]),
      .in_data   (bus.adc_data),
      .out_valid (w_dec_valid[g]),
      .out_data  (w_dec_data[g])
    );
  end

  assign bus.wr_en1 = r_wr_en1;
  assign bus.din1   = r_din1;
  assign bus.wr_en2 = w_dec_valid[0];
  assign bus.din2   = w_dec_data[0];
  assign bus.wr_en4 = w_dec_valid[1];
  assign bus.din4   = w_dec_data[1];
  assign bus.wr_en8 = w_dec_valid[2];
  assign bus.din8   = w_dec_data[2];

  // A write strobe presented while its FIFO reports full
  assign w_ovf = (r_wr_en1 && bus.ffull1) || (w_dec_valid[0] && bus.ffull2) ||
                 (w_dec_valid[1] && bus.ffull4) || (w_dec_valid[2] && bus.ffull8);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_n      <= '0;
      r_seen   <= 1'b0;
      r_wr_en1 <= 1'b0;
      r_din1   <= '0;
      full     <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      r_wr_en1 <= w_accept && (r_n < CNT_W'(SAMPLES));
      if (w_accept) begin
        r_din1 <= bus.adc_data;
      end
      overflow <= overflow || w_ovf;
      case (r_state)
        IDLE: begin
          if (arm) begin
            r_state  <= CAPTURE;
            busy     <= 1'b1;
            r_n      <= '0;
            overflow <= 1'b0;
          end
        end
        CAPTURE: begin
          if (bus.adc_valid) begin
            r_n <= r_n + CNT_W'(1);
            if (r_n == LAST_N) begin
              r_state <= DONE;
              busy    <= 1'b0;
            end
          end
        end
        DONE: begin
          // Exit only after the reader has been seen to pull entries out
          if (r_seen && w_all_empty) begin
            r_state <= IDLE;
            r_seen  <= 1'b0;
            full    <= 1'b0;
          end else begin
            full <= 1'b1;
            if (!w_all_empty) begin
              r_seen <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_seen  <= 1'b0;
          full    <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Scoreboard bench for adc_capture_ctrl with SAMPLES=16, DATA_W=14.
// Expected FIFO entries are queued per capture and checked by a monitor on write strobes.
module tb_adc_capture_ctrl;

  localparam int unsigned DATA_W  = 14;
  localparam int unsigned SAMPLES = 16;
  localparam int          NS      = 8 * SAMPLES;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic arm  = 1'b0;
  logic full, busy, overflow;

  adc_capture_ctrl_if #(.DATA_W(DATA_W)) bus ();

  adc_capture_ctrl #(
    .DATA_W  (DATA_W),
    .SAMPLES (SAMPLES)
  ) u_dut (
    .clk      (clk),
    .rstn     (rstn),
    .arm      (arm),
    .bus      (bus.master),
    .full     (full),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int q1[$], q2[$], q4[$], q8[$];
  bit tb_cap      = 1'b0;
  bit last_accept = 1'b0;
  int acc_cnt     = 0;
  int busy_cnt    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: inputs already set are sampled at the coming posedge
  task automatic tick();
    bit acc;
    acc = bus.adc_valid && tb_cap;
    if (busy) busy_cnt++;
    @(posedge clk);
    #1;
    last_accept = acc;
    if (acc) begin
      acc_cnt++;
      if (acc_cnt == NS) tb_cap = 1'b0;
    end
  endtask

  task automatic do_arm();
    busy_cnt = 0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tb_cap  = 1'b1;
    acc_cnt = 0;
  endtask

  task automatic drive(input int base, input int from, input int upto, input int gap, input bit konst);
    for (int n = from; n < upto; n++) begin
      for (int g = 0; g < gap; g++) begin
        bus.adc_valid = 1'b0;
        bus.adc_data  = 14'h2AAA;
        tick();
      end
      bus.adc_valid = 1'b1;
      bus.adc_data  = konst ? 14'h3FFF : DATA_W'(base + n);
      tick();
    end
    bus.adc_valid = 1'b0;
  endtask

  task automatic push_ramp(input int base);
    for (int i = 0; i < SAMPLES; i++) begin
      q1.push_back(base + i);
      q2.push_back(base + 2 * i);
      q4.push_back(base + 4 * i + 1);
      q8.push_back(base + 8 * i + 3);
    end
  endtask

  task automatic push_const();
    for (int i = 0; i < SAMPLES; i++) begin
      q1.push_back(16383);
      q2.push_back(16383);
      q4.push_back(16383);
      q8.push_back(16383);
    end
  endtask

  task automatic check_queues_empty(input string tag);
    check({tag, "_fifo1_pending"}, q1.size(), 0);
    check({tag, "_fifo2_pending"}, q2.size(), 0);
    check({tag, "_fifo4_pending"}, q4.size(), 0);
    check({tag, "_fifo8_pending"}, q8.size(), 0);
  endtask

  // Called right after the final accept: full must lag the last wr_en8 by one cycle
  task automatic finish_full(input string tag, input int exp_busy);
    @(negedge clk);
    check({tag, "_full_before_last_wr8"}, full, 0);
    check({tag, "_busy_off"}, busy, 0);
    tick();
    @(negedge clk);
    check({tag, "_full_rise"}, full, 1);
    check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
    check_queues_empty(tag);
  endtask

  task automatic drain(input string tag, input bit arm_at_exit);
    bus.adc_valid = 1'b1;
    bus.adc_data  = 14'd5000;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      check({tag, "_full_hold_all_empty"}, full, 1);
    end
    bus.empty1 = 1'b0;
    tick();
    @(negedge clk);
    check({tag, "_full_while_reading"}, full, 1);
    bus.empty1 = 1'b1;
    arm = arm_at_exit;
    tick();
    arm = 1'b0;
    @(negedge clk);
    check({tag, "_full_clear"}, full, 0);
    check({tag, "_busy_after_exit"}, busy, 0);
    tick();
    @(negedge clk);
    check({tag, "_no_capture_after_exit"}, busy, 0);
    bus.adc_valid = 1'b0;
  endtask

  task automatic pop_cmp(input int k, input logic [DATA_W-1:0] act);
    int sz;
    int exp;
    case (k)
      1:       sz = q1.size();
      2:       sz = q2.size();
      4:       sz = q4.size();
      default: sz = q8.size();
    endcase
    if (sz == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL fifo%0d_extra_write: got din %0d, expected no write (t=%0t)", k, act, $time);
      return;
    end
    case (k)
      1:       exp = q1.pop_front();
      2:       exp = q2.pop_front();
      4:       exp = q4.pop_front();
      default: exp = q8.pop_front();
    endcase
    check($sformatf("fifo%0d_din", k), 32'(act), exp);
  endtask

  // Monitor: compares every FIFO write against the scoreboard queues
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (bus.wr_en1) pop_cmp(1, bus.din1);
        if (bus.wr_en2) pop_cmp(2, bus.din2);
        if (bus.wr_en4) pop_cmp(4, bus.din4);
        if (bus.wr_en8) pop_cmp(8, bus.din8);
        if (!last_accept)
          check("wr_en_without_accept",
                32'({bus.wr_en1, bus.wr_en2, bus.wr_en4, bus.wr_en8}), 0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.adc_valid = 1'b0;
    bus.adc_data  = '0;
    {bus.empty1, bus.empty2, bus.empty4, bus.empty8} = 4'b1111;
    {bus.ffull1, bus.ffull2, bus.ffull4, bus.ffull8} = 4'b0000;
    fork
      monitor();
    join_none

    // 1: reset values, then idle samples are ignored
    #12;
    check("rst_full", full, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_wr_en", 32'({bus.wr_en1, bus.wr_en2, bus.wr_en4, bus.wr_en8}), 0);
    #11;
    rstn = 1'b1;
    bus.adc_valid = 1'b1;
    bus.adc_data  = 14'd777;
    for (int i = 0; i < 4; i++) tick();
    bus.adc_valid = 1'b0;

    // 2: contiguous ramp, arm mid-capture ignored, arm at exit ignored
    push_ramp(0);
    do_arm();
    drive(0, 0, 64, 0, 1'b0);
    arm = 1'b1;
    drive(0, 64, 65, 0, 1'b0);
    arm = 1'b0;
    drive(0, 65, NS, 0, 1'b0);
    finish_full("ramp", NS);
    check("ramp_overflow", overflow, 0);
    drain("ramp", 1'b1);

    // 3: same ramp with valid only every third cycle
    push_ramp(0);
    do_arm();
    drive(0, 0, NS, 2, 1'b0);
    finish_full("gapped", 3 * NS);
    drain("gapped", 1'b0);

    // 4+6: full-scale constant with FIFO4 reporting full
    bus.ffull4 = 1'b1;
    push_const();
    do_arm();
    drive(0, 0, 4, 0, 1'b1);
    @(negedge clk);
    check("ovf_before_first_wr4", overflow, 0);
    drive(0, 4, 5, 0, 1'b1);
    @(negedge clk);
    check("ovf_after_first_wr4", overflow, 1);
    drive(0, 5, NS, 0, 1'b1);
    finish_full("const", NS);
    check("ovf_in_done", overflow, 1);
    drain("const", 1'b0);
    check("ovf_sticky_idle", overflow, 1);
    bus.ffull4 = 1'b0;

    // 7: async reset mid-capture after 50 samples, then restart with offset ramp
    for (int i = 0; i < SAMPLES; i++) begin
      q1.push_back(i);
      q2.push_back(2 * i);
    end
    for (int i = 0; i < 12; i++) q4.push_back(4 * i + 1);
    for (int i = 0; i < 6; i++) q8.push_back(8 * i + 3);
    do_arm();
    check("rearm_clears_ovf", overflow, 0);
    drive(0, 0, 50, 0, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_full", full, 0);
    check("async_rst_wr_en", 32'({bus.wr_en1, bus.wr_en2, bus.wr_en4, bus.wr_en8}), 0);
    check("async_rst_din1", 32'(bus.din1), 0);
    tb_cap      = 1'b0;
    last_accept = 1'b0;
    check_queues_empty("abort");
    @(posedge clk);
    @(posedge clk);
    #3;
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    push_ramp(100);
    do_arm();
    drive(100, 0, NS, 0, 1'b0);
    finish_full("restart", NS);
    drain("restart", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
